// File: rtl/tick_timer_sched.sv
// Prescaled tick generator driving CH independent one-shot tick-count timers.
// Optional auto-reload per channel is compiled in when TIMER_AUTO_RELOAD_EN is defined.
module tick_timer_sched #(
  parameter int unsigned N  = 17,
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pause,
  input  logic [CH-1:0] start,
  input  logic [CH-1:0] cancel,
  input  logic [CH*W-1:0] load_val,
`ifdef TIMER_AUTO_RELOAD_EN
  input  logic [CH-1:0] reload,
`endif
  output logic          tick,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [N-1:0]  presc;
  logic [CH-1:0] reload_en;

`ifdef TIMER_AUTO_RELOAD_EN
  assign reload_en = reload;
`else
  assign reload_en = '0;
`endif

  // Free-running prescaler; tick is the registered wrap indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (!pause) begin
      presc <= presc + N'(1);
      tick  <= (presc == '1);
    end else begin
      tick  <= 1'b0;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t       state;
    logic [W-1:0] rem;
    logic [W-1:0] lv;
    logic         busy_q;
    logic         done_q;

    assign lv = load_val[i*W +: W];

    // Priority: cancel > start > tick-driven countdown. Pause freezes rem even
    // in the single cycle where a tick issued before the pause is still visible.
    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        rem    <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (cancel[i]) begin
          state  <= IDLE;
          rem    <= '0;
          busy_q <= 1'b0;
        end else if (start[i]) begin
          if (lv != '0) begin
            state  <= RUN;
            rem    <= lv;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            rem    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else if (state == RUN && tick && !pause) begin
          if (rem == W'(1)) begin
            done_q <= 1'b1;
            if (reload_en[i] && lv != '0) begin
              rem <= lv;
            end else begin
              state  <= IDLE;
              rem    <= '0;
              busy_q <= 1'b0;
            end
          end else begin
            rem <= rem - W'(1);
          end
        end
      end
    end

    assign busy[i] = busy_q;
    assign done[i] = done_q;
  end

endmodule

// File: doc/tick_timer_sched.md
TICK_TIMER_SCHED -- requirements
Module: tick_timer_sched

Interface
REQ-001 SHALL have parameter N, default 17: prescaler width; tick period is 2^N clk cycles.
REQ-002 SHALL have parameter CH, default 4: number of independent timer channels.
REQ-003 SHALL have parameter W, default 8: per-channel count width, in ticks.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port pause  input  1: when high, the prescaler holds and no tick is generated.
REQ-007 SHALL have port start  input  CH: per-channel start/restart strobe.
REQ-008 SHALL have port cancel  input  CH: per-channel abort strobe.
REQ-009 SHALL have port load_val  input  CH*W: channel i duration, in ticks, at bits [i*W +: W].
REQ-010 SHALL have port tick  output  1: one-cycle pulse at each prescaler wrap.
REQ-011 SHALL have port busy  output  CH: channel i is counting.
REQ-012 SHALL have port done  output  CH: one-cycle expiry pulse per channel.

Function
REQ-013 Prescaler SHALL be an N-bit up-counter, incrementing every cycle that pause is low, wrapping 2^N-1 -> 0.
REQ-014 tick SHALL be registered and high for exactly the cycle after the counter goes 2^N-1 -> 0; it SHALL be low whenever pause was high in the previous cycle.
REQ-015 Each channel SHALL be a 2-state FSM, IDLE (busy=0) / RUN (busy=1), with a W-bit remaining-count register rem.
REQ-016 start[i] with load_val_i != 0, in any state, SHALL set rem=load_val_i and state=RUN next cycle; restart while RUN SHALL discard the old count without a done pulse.
REQ-017 start[i] with load_val_i == 0 SHALL leave the channel in IDLE and pulse done[i] in the next cycle.
REQ-018 In RUN, each tick-high cycle SHALL decrement rem; tick with rem==1 SHALL make state IDLE, busy=0 and done[i]=1 in the next cycle.
REQ-019 Expiry SHALL occur between load_val-1 and load_val tick periods after start, depending on prescaler phase; the prescaler SHALL NOT be reset by start.
REQ-020 cancel[i] SHALL force IDLE next cycle with no done pulse; cancel SHALL win over a simultaneous start and over a simultaneous expiry.
REQ-021 start[i] in the same cycle as tick SHALL load load_val_i and ignore that tick for channel i.
REQ-022 done SHALL never be high for two consecutive cycles on one channel, except when start with load_val 0 is repeated.
REQ-023 Channels SHALL be fully independent; any combination of simultaneous starts, cancels and expiries across channels SHALL be legal.
REQ-024 pause SHALL freeze rem in all channels; start and cancel SHALL still take effect while paused.

Reset
REQ-025 While reset is high at a clk edge: prescaler=0, all channels IDLE, rem=0, tick=0, busy=0, done=0.
REQ-026 Reset SHALL override start, cancel and pause; reset mid-count SHALL abort without a done pulse.
REQ-027 The first tick after reset release SHALL occur 2^N cycles later when pause stays low.

Configuration
REQ-028 When macro TIMER_AUTO_RELOAD_EN is defined, input reload (CH bits) SHALL exist; on expiry with reload[i]=1, channel i SHALL pulse done[i], stay RUN and reload rem=load_val_i (0 -> go IDLE).
REQ-029 When TIMER_AUTO_RELOAD_EN is undefined, the reload port SHALL be absent and all channels SHALL be one-shot, per REQ-018.

Verification (N=4, CH=4, W=8; tick period 16 cycles)
REQ-030 Reset, then 64 cycles with pause=0 -> tick pulses at cycles 16, 32, 48, 64 after release; busy=0 and done=0 throughout.
REQ-031 start[0] with load_val=3, applied in the cycle immediately after a tick -> busy[0]=1 for about 48 cycles, then one done[0] pulse in the cycle after the 3rd tick, then busy[0]=0.
REQ-032 start[1] with load_val=5; cancel[1] after 2 ticks; plus start[2] and cancel[2] in the same cycle -> busy[1] clears next cycle, channel 2 never becomes busy, no done[1] or done[2] ever.
REQ-033 start[3] with load_val=2, pause=1 for 40 cycles mid-count, then pause=0 -> no ticks and rem held during the pause; done[3] after the 2nd real tick.
REQ-034 start[0] with load_val=0 -> done[0] pulses next cycle and busy[0] stays 0; start[0] with load_val=4 coinciding with tick -> expiry after exactly 4 further ticks.
REQ-035 With TIMER_AUTO_RELOAD_EN, reload[0]=1 and load_val=2 -> done[0] every 32 cycles and busy[0] held at 1; reset asserted mid-run -> all outputs 0 next cycle.
